// File: rtl/NanoCore_pkg.sv
// Shared NanoCore types for the load/store memory back end: request, writeback,
// pending-queue entry, access-size encoding and alignment helpers.
package NanoCore_pkg;

  localparam logic [1:0] MEM_SIZE_WORD = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_BYTE = 2'b10;

  typedef struct packed {
    logic [7:0]  uid;
    logic [4:0]  rf_dst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  mem_wordsize;
    logic        we;
    logic        is_lb;
    logic        is_lh;
    logic        is_lu;
  } lsu_ctl_t;

  typedef struct packed {
    logic        ready;
    logic [7:0]  uid;
    logic [4:0]  rf_dst;
    logic [31:0] rf_wdata;
  } wb_entry_t;

  typedef struct packed {
    logic       we;
    logic [1:0] off;
    logic       is_lb;
    logic       is_lh;
    logic       is_lu;
    logic [4:0] rf_dst;
    logic [7:0] uid;
  } lsu_pend_t;

  typedef enum logic {
    LSU_IDLE,
    LSU_REQ
  } lsu_req_state_e;

  // Byte wins over half when both flags are set.
  function automatic logic [1:0] lsu_access_size(input logic is_lb, input logic is_lh);
    if (is_lb) return MEM_SIZE_BYTE;
    if (is_lh) return MEM_SIZE_HALF;
    return MEM_SIZE_WORD;
  endfunction

  function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == MEM_SIZE_WORD) && (off != 2'b00)) ||
           ((size == MEM_SIZE_HALF) && off[0]);
  endfunction

endpackage

// File: rtl/nanocore_lsu_pend_fifo.sv
// In-order queue of granted accesses awaiting their memory response; a push and
// a pop in the same cycle are accepted even when the queue is full.
module nanocore_lsu_pend_fifo
  import NanoCore_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_push,
  input  lsu_pend_t                    i_push_data,
  input  logic                         i_pop,
  output lsu_pend_t                    o_head,
  output logic [$clog2(DEPTH+1)-1:0]   o_count,
  output logic                         o_full,
  output logic                         o_empty
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  lsu_pend_t     mem_q [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_eff, pop_eff;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign o_count = count_q;
  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_head  = mem_q[rd_q];

  // When full, a push rides on the simultaneous pop freeing the head slot.
  assign pop_eff  = i_pop && !o_empty;
  assign push_eff = i_push && (!o_full || pop_eff);

  always_comb begin
    wr_d    = push_eff ? ptr_next(wr_q) : wr_q;
    rd_d    = pop_eff  ? ptr_next(rd_q) : rd_q;
    count_d = count_q + CW'(push_eff) - CW'(pop_eff);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push_eff) mem_q[wr_q] <= i_push_data;
  end

endmodule

// File: rtl/nanocore_lsu_mem_if.sv
// NanoCore LSU memory back end: issues requests on the req/gnt/rvalid bus, tracks
// outstanding accesses in order, and returns aligned load writebacks or store completions.
module nanocore_lsu_mem_if
  import NanoCore_pkg::*;
#(
  parameter int PEND_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_lsu_valid,
  input  lsu_ctl_t    i_lsu_ctl,
  output logic        o_lsu_ready,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  output logic [3:0]  o_mem_wstrb,
  input  logic        i_mem_gnt,
  input  logic        i_mem_rvalid,
  input  logic [31:0] i_mem_rdata,
  output wb_entry_t   o_wb,
  output logic        o_st_done,
  output logic [7:0]  o_st_uid,
  output logic        o_misalign,
  output logic [7:0]  o_misalign_uid,
  output logic        o_err_spurious
);
  localparam int CW = $clog2(PEND_DEPTH + 1);

  lsu_req_state_e state_q, state_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]  mem_wstrb_q, mem_wstrb_d;
  lsu_pend_t   pend_q, pend_d;
  wb_entry_t   wb_q, wb_d;
  logic        st_done_q, st_done_d;
  logic [7:0]  st_uid_q, st_uid_d;
  logic        misalign_q, misalign_d;
  logic [7:0]  misalign_uid_q, misalign_uid_d;
  logic        err_spur_q, err_spur_d;

  logic [CW-1:0] pend_count;
  logic          pend_full, pend_empty, pend_push, pend_pop;
  lsu_pend_t     pend_head;
  logic          accept, misaligned;
  logic [1:0]    size;
  logic [15:0]   lane_data;
  logic [31:0]   load_data;
  logic          unused_bits;

  // Size comes from the flags; the encoded size field is only carried for upstream use.
  assign unused_bits = pend_full ^ (^i_lsu_ctl.mem_wordsize);

  assign size        = lsu_access_size(i_lsu_ctl.is_lb, i_lsu_ctl.is_lh);
  assign misaligned  = lsu_misaligned(size, i_lsu_ctl.addr[1:0]);
  assign o_lsu_ready = (state_q == LSU_IDLE) && (pend_count < CW'(PEND_DEPTH));
  assign accept      = i_lsu_valid && o_lsu_ready;
  assign pend_push   = (state_q == LSU_REQ) && i_mem_gnt;
  assign pend_pop    = i_mem_rvalid && !pend_empty;

  nanocore_lsu_pend_fifo #(.DEPTH(PEND_DEPTH)) u_pend_fifo (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (pend_push),
    .i_push_data (pend_q),
    .i_pop       (pend_pop),
    .o_head      (pend_head),
    .o_count     (pend_count),
    .o_full      (pend_full),
    .o_empty     (pend_empty)
  );

  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    pend_d      = pend_q;
    case (state_q)
      LSU_IDLE: begin
        if (accept && !misaligned) begin
          state_d     = LSU_REQ;
          mem_we_d    = i_lsu_ctl.we;
          mem_addr_d  = {i_lsu_ctl.addr[31:2], 2'b00};
          mem_wdata_d = i_lsu_ctl.wdata;
          mem_wstrb_d = i_lsu_ctl.wstrb;
          pend_d      = '{we: i_lsu_ctl.we, off: i_lsu_ctl.addr[1:0],
                          is_lb: i_lsu_ctl.is_lb, is_lh: i_lsu_ctl.is_lh,
                          is_lu: i_lsu_ctl.is_lu, rf_dst: i_lsu_ctl.rf_dst,
                          uid: i_lsu_ctl.uid};
        end
      end
      LSU_REQ: if (i_mem_gnt) state_d = LSU_IDLE;
      default: state_d = LSU_IDLE;
    endcase
  end

  always_comb begin
    lane_data = 16'(i_mem_rdata >> {pend_head.off, 3'b000});
    load_data = i_mem_rdata;
    if (pend_head.is_lb)
      load_data = {{24{lane_data[7] & ~pend_head.is_lu}}, lane_data[7:0]};
    else if (pend_head.is_lh)
      load_data = {{16{lane_data[15] & ~pend_head.is_lu}}, lane_data[15:0]};
    if (pend_head.rf_dst == 5'd0) load_data = '0;
  end

  // Completions and error flags are registered, so each pulse lands one cycle after its cause.
  always_comb begin
    wb_d           = '0;
    st_done_d      = 1'b0;
    st_uid_d       = '0;
    misalign_d     = accept && misaligned;
    misalign_uid_d = (accept && misaligned) ? i_lsu_ctl.uid : 8'h00;
    err_spur_d     = err_spur_q;
    if (i_mem_rvalid) begin
      if (pend_empty) begin
        err_spur_d = 1'b1;
      end else if (pend_head.we) begin
        st_done_d = 1'b1;
        st_uid_d  = pend_head.uid;
      end else begin
        wb_d = '{ready: 1'b1, uid: pend_head.uid, rf_dst: pend_head.rf_dst,
                 rf_wdata: load_data};
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= LSU_IDLE;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      mem_wstrb_q    <= '0;
      pend_q         <= '0;
      wb_q           <= '0;
      st_done_q      <= 1'b0;
      st_uid_q       <= '0;
      misalign_q     <= 1'b0;
      misalign_uid_q <= '0;
      err_spur_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      mem_wstrb_q    <= mem_wstrb_d;
      pend_q         <= pend_d;
      wb_q           <= wb_d;
      st_done_q      <= st_done_d;
      st_uid_q       <= st_uid_d;
      misalign_q     <= misalign_d;
      misalign_uid_q <= misalign_uid_d;
      err_spur_q     <= err_spur_d;
    end
  end

  assign o_mem_req      = (state_q == LSU_REQ);
  assign o_mem_we       = mem_we_q;
  assign o_mem_addr     = mem_addr_q;
  assign o_mem_wdata    = mem_wdata_q;
  assign o_mem_wstrb    = mem_wstrb_q;
  assign o_wb           = wb_q;
  assign o_st_done      = st_done_q;
  assign o_st_uid       = st_uid_q;
  assign o_misalign     = misalign_q;
  assign o_misalign_uid = misalign_uid_q;
  assign o_err_spurious = err_spur_q;

endmodule

// File: tb/tb_nanocore_lsu_mem_if.sv
// Self-checking bench for nanocore_lsu_mem_if: directed scenarios with literal
// expectations plus randomized traffic against a queue-based behavioural model.
module tb_nanocore_lsu_mem_if;
  import NanoCore_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        lsuValid = 1'b0;
  lsu_ctl_t    lsuCtl = '0;
  logic        lsuReady;
  logic        memReq, memWe;
  logic [31:0] memAddr, memWdata;
  logic [3:0]  memWstrb;
  logic        memGnt = 1'b0;
  logic        memRvalid = 1'b0;
  logic [31:0] memRdata = '0;
  wb_entry_t   wb;
  logic        stDone;
  logic [7:0]  stUid;
  logic        misalign;
  logic [7:0]  misalignUid;
  logic        errSpurious;

  always #5 clk = ~clk;

  nanocore_lsu_mem_if #(.PEND_DEPTH(DEPTH)) dut (
    .i_clk          (clk),
    .i_rst_n        (rstN),
    .i_lsu_valid    (lsuValid),
    .i_lsu_ctl      (lsuCtl),
    .o_lsu_ready    (lsuReady),
    .o_mem_req      (memReq),
    .o_mem_we       (memWe),
    .o_mem_addr     (memAddr),
    .o_mem_wdata    (memWdata),
    .o_mem_wstrb    (memWstrb),
    .i_mem_gnt      (memGnt),
    .i_mem_rvalid   (memRvalid),
    .i_mem_rdata    (memRdata),
    .o_wb           (wb),
    .o_st_done      (stDone),
    .o_st_uid       (stUid),
    .o_misalign     (misalign),
    .o_misalign_uid (misalignUid),
    .o_err_spurious (errSpurious)
  );

  int nVectors = 0;
  int nMiscompares = 0;

  // Behavioural model: one request waiting for grant, then a FIFO of granted accesses.
  bit        busy;
  lsu_ctl_t  reqItem;
  lsu_ctl_t  pendQ[$];
  bit        expWbValid;
  wb_entry_t expWb;
  bit        expStDone;
  logic [7:0] expStUid;
  bit        expMis;
  logic [7:0] expMisUid;
  bit        expErr;

  function automatic void modelReset();
    busy = 0; reqItem = '0; pendQ.delete();
    expWbValid = 0; expWb = '0; expStDone = 0; expStUid = '0;
    expMis = 0; expMisUid = '0; expErr = 0;
  endfunction

  function automatic bit isMisaligned(lsu_ctl_t c);
    if (c.is_lb) return 0;
    if (c.is_lh) return c.addr[0];
    return c.addr[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] loadValue(lsu_ctl_t c, logic [31:0] word);
    int unsigned shift;
    int width;
    logic [31:0] raw;
    if (c.rf_dst == 5'd0) return 32'd0;
    if (c.is_lb) width = 8;
    else if (c.is_lh) width = 16;
    else return word;
    shift = 8 * int'(c.addr[1:0]);
    raw = (word >> shift) & ((32'd1 << width) - 32'd1);
    if (!c.is_lu && raw >= (32'd1 << (width - 1))) raw = raw - (32'd1 << width);
    return raw;
  endfunction

  function automatic lsu_ctl_t makeCtl(logic [7:0] uid, logic [4:0] rf, logic [31:0] addr,
                                       bit we, int sz, bit lu, logic [31:0] wdata,
                                       logic [3:0] wstrb);
    lsu_ctl_t c;
    c = '0;
    c.uid = uid; c.rf_dst = rf; c.addr = addr; c.we = we; c.is_lu = lu;
    c.wdata = wdata; c.wstrb = wstrb;
    c.is_lb = (sz == 2); c.is_lh = (sz == 1);
    c.mem_wordsize = (sz == 2) ? MEM_SIZE_BYTE : (sz == 1) ? MEM_SIZE_HALF : MEM_SIZE_WORD;
    return c;
  endfunction

  // Advances the model across one clock edge given the inputs held during that edge.
  function automatic void modelStep(bit valid, lsu_ctl_t ctl, bit gnt, bit rvalid,
                                    logic [31:0] rdata);
    bit readyNow;
    lsu_ctl_t h;
    readyNow = !busy && (pendQ.size() < DEPTH);
    expWbValid = 0; expStDone = 0; expMis = 0;
    if (rvalid) begin
      if (pendQ.size() == 0) expErr = 1;
      else begin
        h = pendQ.pop_front();
        if (h.we) begin
          expStDone = 1; expStUid = h.uid;
        end else begin
          expWbValid = 1;
          expWb.ready = 1'b1; expWb.uid = h.uid; expWb.rf_dst = h.rf_dst;
          expWb.rf_wdata = loadValue(h, rdata);
        end
      end
    end
    if (busy && gnt) begin
      pendQ.push_back(reqItem);
      busy = 0;
    end
    if (valid && readyNow) begin
      if (isMisaligned(ctl)) begin
        expMis = 1; expMisUid = ctl.uid;
      end else begin
        busy = 1; reqItem = ctl;
      end
    end
  endfunction

  task automatic checkValue(input string name, input logic [31:0] actual,
                            input logic [31:0] expected);
    nVectors++;
    if (actual !== expected) begin
      nMiscompares++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, expected 0x%08h", name, $time, actual, expected);
    end
  endtask

  task automatic checkOutput();
    checkValue("lsu_ready", 32'(lsuReady), 32'(!busy && (pendQ.size() < DEPTH)));
    checkValue("mem_req", 32'(memReq), 32'(busy));
    if (busy) begin
      checkValue("mem_we", 32'(memWe), 32'(reqItem.we));
      checkValue("mem_addr", memAddr, {reqItem.addr[31:2], 2'b00});
      if (reqItem.we) begin
        checkValue("mem_wdata", memWdata, reqItem.wdata);
        checkValue("mem_wstrb", 32'(memWstrb), 32'(reqItem.wstrb));
      end
    end
    checkValue("wb_ready", 32'(wb.ready), 32'(expWbValid));
    if (expWbValid) begin
      checkValue("wb_uid", 32'(wb.uid), 32'(expWb.uid));
      checkValue("wb_rf_dst", 32'(wb.rf_dst), 32'(expWb.rf_dst));
      checkValue("wb_data", wb.rf_wdata, expWb.rf_wdata);
    end
    checkValue("st_done", 32'(stDone), 32'(expStDone));
    if (expStDone) checkValue("st_uid", 32'(stUid), 32'(expStUid));
    checkValue("misalign", 32'(misalign), 32'(expMis));
    if (expMis) checkValue("misalign_uid", 32'(misalignUid), 32'(expMisUid));
    checkValue("err_spurious", 32'(errSpurious), 32'(expErr));
  endtask

  // Called at a negedge: compare the current outputs, drive inputs, cross one posedge.
  task automatic applyStimulus(input bit valid, input lsu_ctl_t ctl, input bit gnt,
                               input bit rvalid, input logic [31:0] rdata);
    checkOutput();
    lsuValid = valid; lsuCtl = ctl; memGnt = gnt; memRvalid = rvalid; memRdata = rdata;
    modelStep(valid, ctl, gnt, rvalid, rdata);
    @(posedge clk);
    @(negedge clk);
    lsuValid = 1'b0; memGnt = 1'b0; memRvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, '0, 0, 0, 32'h0);
  endtask

  task automatic checkAllZero(input string tag);
    checkValue({tag, "_mem_req"}, 32'(memReq), 32'd0);
    checkValue({tag, "_mem_we"}, 32'(memWe), 32'd0);
    checkValue({tag, "_mem_addr"}, memAddr, 32'd0);
    checkValue({tag, "_mem_wdata"}, memWdata, 32'd0);
    checkValue({tag, "_mem_wstrb"}, 32'(memWstrb), 32'd0);
    checkValue({tag, "_wb_ready"}, 32'(wb.ready), 32'd0);
    checkValue({tag, "_wb_data"}, wb.rf_wdata, 32'd0);
    checkValue({tag, "_st_done"}, 32'(stDone), 32'd0);
    checkValue({tag, "_misalign"}, 32'(misalign), 32'd0);
    checkValue({tag, "_err"}, 32'(errSpurious), 32'd0);
  endtask

  initial begin
    lsu_ctl_t c, c1, c2, c3;
    logic [7:0] uidCnt;
    modelReset();
    repeat (3) @(negedge clk);
    checkAllZero("reset");
    rstN = 1'b1;
    #1;
    checkValue("ready_after_reset", 32'(lsuReady), 32'd1);

    // Signed byte load: lane 0 of 0x104.
    c = makeCtl(8'h11, 5'd5, 32'h104, 0, 2, 0, 32'h0, 4'h0);
    applyStimulus(1, c, 0, 0, 0);
    checkValue("lb_req", 32'(memReq), 32'd1);
    checkValue("lb_addr", memAddr, 32'h104);
    applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(0, '0, 0, 1, 32'h1234_5680);
    checkValue("lb_wb_ready", 32'(wb.ready), 32'd1);
    checkValue("lb_wb_data", wb.rf_wdata, 32'hFFFF_FF80);
    checkValue("lb_wb_uid", 32'(wb.uid), 32'h11);

    // Unsigned halfword load from the upper lane.
    c = makeCtl(8'h12, 5'd7, 32'h102, 0, 1, 1, 32'h0, 4'h0);
    applyStimulus(1, c, 0, 0, 0);
    checkValue("lhu_addr", memAddr, 32'h100);
    applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(0, '0, 0, 1, 32'h8001_0000);
    checkValue("lhu_wb_data", wb.rf_wdata, 32'h0000_8001);

    // Store with the grant held off for three cycles.
    c = makeCtl(8'h13, 5'd0, 32'h200, 1, 0, 0, 32'hDEAD_BEEF, 4'hF);
    applyStimulus(1, c, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      checkValue("sw_hold_req", 32'(memReq), 32'd1);
      checkValue("sw_hold_addr", memAddr, 32'h200);
      checkValue("sw_hold_wdata", memWdata, 32'hDEAD_BEEF);
      checkValue("sw_hold_wstrb", 32'(memWstrb), 32'hF);
      applyStimulus(0, '0, 0, 0, 0);
    end
    applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(0, '0, 0, 1, $urandom);
    checkValue("sw_done", 32'(stDone), 32'd1);
    checkValue("sw_uid", 32'(stUid), 32'h13);
    checkValue("sw_no_wb", 32'(wb.ready), 32'd0);

    // Misaligned word load never reaches the bus.
    c = makeCtl(8'h14, 5'd3, 32'h103, 0, 0, 0, 32'h0, 4'h0);
    applyStimulus(1, c, 0, 0, 0);
    checkValue("mis_pulse", 32'(misalign), 32'd1);
    checkValue("mis_uid", 32'(misalignUid), 32'h14);
    checkValue("mis_no_req", 32'(memReq), 32'd0);
    checkValue("mis_ready", 32'(lsuReady), 32'd1);

    // Fill the queue, then free a slot with the first response.
    c1 = makeCtl(8'h21, 5'd1, 32'h300, 0, 0, 0, 32'h0, 4'h0);
    c2 = makeCtl(8'h22, 5'd2, 32'h305, 0, 2, 0, 32'h0, 4'h0);
    c3 = makeCtl(8'h23, 5'd3, 32'h306, 0, 1, 0, 32'h0, 4'h0);
    applyStimulus(1, c1, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(1, c2, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0);
    checkValue("full_not_ready", 32'(lsuReady), 32'd0);
    applyStimulus(1, c3, 0, 1, 32'hA5A5_1234);
    checkValue("full_wb1_uid", 32'(wb.uid), 32'h21);
    checkValue("full_ready_again", 32'(lsuReady), 32'd1);
    applyStimulus(1, c3, 0, 0, 0);
    checkValue("full_third_req", 32'(memReq), 32'd1);
    applyStimulus(0, '0, 1, 0, 0);
    applyStimulus(0, '0, 0, 1, 32'h0000_7F00);
    checkValue("full_wb2_uid", 32'(wb.uid), 32'h22);
    checkValue("full_wb2_data", wb.rf_wdata, 32'h0000_007F);
    applyStimulus(0, '0, 0, 1, 32'h8000_0000);
    checkValue("full_wb3_uid", 32'(wb.uid), 32'h23);
    checkValue("full_wb3_data", wb.rf_wdata, 32'hFFFF_8000);

    // Randomized traffic; responses only when something is outstanding.
    uidCnt = 8'h40;
    for (int i = 0; i < 1500; i++) begin
      bit v, g, r;
      v = ($urandom_range(0, 1) == 1);
      c = makeCtl(uidCnt, 5'($urandom_range(0, 31)), 32'h400 + 32'($urandom_range(0, 63)),
                  bit'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                  bit'($urandom_range(0, 1)), $urandom, 4'($urandom));
      g = busy && ($urandom_range(0, 1) == 1);
      r = (pendQ.size() > 0) && ($urandom_range(0, 2) != 0);
      applyStimulus(v, c, g, r, $urandom);
      if (v) uidCnt++;
    end
    for (int i = 0; i < 20; i++) applyStimulus(0, '0, busy, pendQ.size() > 0, $urandom);
    checkValue("drained_ready", 32'(lsuReady), 32'd1);

    // Response with nothing outstanding sets the sticky error.
    applyStimulus(0, '0, 0, 1, 32'h1111_2222);
    checkValue("spurious_set", 32'(errSpurious), 32'd1);
    checkValue("spurious_no_wb", 32'(wb.ready), 32'd0);
    idle(3);
    checkValue("spurious_sticky", 32'(errSpurious), 32'd1);

    // Reset with one load queued discards it.
    c = makeCtl(8'h31, 5'd9, 32'h500, 0, 0, 0, 32'h0, 4'h0);
    applyStimulus(1, c, 0, 0, 0);
    applyStimulus(0, '0, 1, 0, 0);
    checkOutput();
    rstN = 1'b0;
    #1;
    checkAllZero("midreset");
    modelReset();
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1;
    checkValue("ready_after_midreset", 32'(lsuReady), 32'd1);
    idle(4);
    checkValue("no_wb_after_reset", 32'(wb.ready), 32'd0);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
    $finish;
  end

endmodule

// File: doc/nanocore_lsu_mem_if.md
# nanocore_lsu_mem_if

Memory-side back end of the NanoCore load/store path. It accepts `lsu_ctl_t` requests from the execute stage, drives them onto the data-memory request/grant/rvalid bus, and keeps a small in-order queue of outstanding accesses. Load responses are aligned and sign- or zero-extended, then returned as `wb_entry_t` register-file writebacks. Store completions are reported by `uid` only.

## Interface

Clock and reset: one clock `i_clk`; reset `i_rst_n` is asynchronous and active-low.

Parameters:
- `PEND_DEPTH`, default 2: maximum number of granted accesses still awaiting `i_mem_rvalid`.

Ports (name, direction, width, meaning):
- `i_clk`, in, 1: clock.
- `i_rst_n`, in, 1: async active-low reset.
- `i_lsu_valid`, in, 1: request valid.
- `i_lsu_ctl`, in, `lsu_ctl_t`: request. `wdata`/`wstrb` arrive already lane-aligned.
- `o_lsu_ready`, out, 1: request accepted when both `i_lsu_valid` and `o_lsu_ready` are high.
- `o_mem_req`, out, 1: bus request.
- `o_mem_we`, out, 1: bus write enable.
- `o_mem_addr`, out, 32: word address, bits [1:0] forced to 0.
- `o_mem_wdata`, out, 32: write data.
- `o_mem_wstrb`, out, 4: byte strobes.
- `i_mem_gnt`, in, 1: request granted this cycle.
- `i_mem_rvalid`, in, 1: response for the oldest granted access.
- `i_mem_rdata`, in, 32: response word.
- `o_wb`, out, `wb_entry_t`: load writeback. `ready` is a 1-cycle valid pulse.
- `o_st_done`, out, 1: store completion pulse.
- `o_st_uid`, out, 8: uid of the completed store.
- `o_misalign`, out, 1: misaligned-access pulse.
- `o_misalign_uid`, out, 8: uid of the misaligned access.
- `o_err_spurious`, out, 1: sticky flag, set by `i_mem_rvalid` arriving with an empty queue.

## Operation

- Access size is taken from the control flags: `is_lb` = byte, `is_lh` = half, otherwise word. `we` marks a store.
- Misalignment check on acceptance:
  - word access with `addr[1:0]` not 0, or half access with `addr[0]=1`, is misaligned;
  - a misaligned access is not sent to the bus and not queued;
  - it raises `o_misalign` with its `uid` in the next cycle;
  - it produces no writeback.
- Request register, states IDLE and REQ:
  - IDLE to REQ on acceptance of an aligned access;
  - REQ to IDLE on `i_mem_gnt`;
  - in REQ, all `o_mem_*` outputs are held stable until granted.
- On grant, a pending entry {`we`, `addr[1:0]`, `is_lb`, `is_lh`, `is_lu`, `rf_dst`, `uid`} is pushed into the queue.
- `o_lsu_ready` = state IDLE and queue count < `PEND_DEPTH`. It is computed from registers only and has no dependence on `i_mem_gnt`.
- On `i_mem_rvalid`, the head entry is popped.
  - Load: byte lane = `addr[1:0]`, half lane = `addr[1]`. Extend to 32 bits: zero-extend if `is_lu`, else sign-extend. Emit `o_wb` = {ready=1, uid, rf_dst, data}.
  - A load with `rf_dst`=0 still emits a writeback with `rf_wdata`=0.
  - Store: `i_mem_rdata` is ignored; emit `o_st_done` with `o_st_uid`.
- Push and pop in the same cycle leave the count unchanged. This is legal when the queue is full.
- `i_mem_rvalid` with an empty queue: the response is dropped and `o_err_spurious` is set. The flag clears only on reset.
- Reset values:
  - state IDLE, queue empty;
  - `o_mem_req`, `o_mem_we`, `o_st_done`, `o_misalign`, `o_err_spurious`, `o_wb.ready` = 0;
  - all data and uid outputs = 0;
  - `o_lsu_ready` = 1 immediately after reset deasserts.
- Reset asserted mid-operation discards all queued and in-flight accesses, with no completion reported. The memory side is reset by the same `i_rst_n`.

## Timing

- Acceptance at cycle N: `o_mem_req` is high from N+1.
- Grant at cycle G ≥ N+1: `o_mem_req` is low at G+1 unless a new request was accepted in G.
  - `o_lsu_ready` is low in G, so back-to-back bus requests occur every 2 cycles at best.
- Response `i_mem_rvalid` at cycle R: `o_wb.ready` or `o_st_done` is high in R+1 for exactly one cycle.
- Minimum load-to-writeback latency is 3 cycles (accept N, grant N+1, rvalid N+2, writeback N+3).
- The earliest response is the cycle after its grant. A response in the same cycle as its own grant is illegal.
- Misaligned access accepted at N: pulse at N+1.
- There is no backpressure on the writeback or completion outputs.

## Structure

- `lsu_ctl_t` and `wb_entry_t` are taken from `NanoCore_pkg`.
- Add to `NanoCore_pkg`:
  - `lsu_pend_t`, the queue entry struct;
  - size localparams for the `lsu_ctl_t.mem_wordsize` encoding: 2'b00 word, 2'b01 half, 2'b10 byte.
- Sub-module `nanocore_lsu_pend_fifo`: synchronous FIFO of `lsu_pend_t`, depth `PEND_DEPTH`, with count, full and empty outputs, and simultaneous push/pop when full.

## Test plan

- **Signed load byte:** `lb` from 0x104 (lane 0 of word 0x104), `i_mem_rdata`=0x1234_5680 one cycle after grant → `o_wb` = {uid, rf_dst, 0xFFFF_FF80} three cycles after acceptance.
- **Unsigned load halfword:** `lhu` from 0x102, rdata=0x8001_0000 → `rf_wdata`=0x0000_8001; `o_mem_addr`=0x100.
- **Store:** `sw` 0x200, wdata=0xDEAD_BEEF, wstrb=0xF, gnt delayed 3 cycles → request fields held constant for 3 cycles; `o_st_done` with the matching uid the cycle after rvalid; no `o_wb`.
- **Misaligned:** `lw` from 0x103 → no `o_mem_req`; `o_misalign`=1 with its uid at N+1; queue count stays 0.
- **Queue full:** two loads granted with rvalid withheld → `o_lsu_ready`=0. Third request accepted the cycle after the first rvalid; writebacks emerge in uid order.
- **Spurious and reset:** rvalid with empty queue → `o_err_spurious`=1 and sticky. Then assert `i_rst_n`=0 with one load queued → all outputs 0 immediately; no writeback after release.
